// File: rtl/conv_pkg.sv
// Shared helpers for the streaming KxK convolution: width math and tap indexing.
package conv_pkg;

  // Ceiling log2, floored at 1 so it can always size a vector.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int out_w(input int data_w, input int coef_w, input int k);
    return data_w + coef_w + clog2(k * k);
  endfunction

  function automatic int tap_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: a DEPTH-deep pixel shift register that advances on i_en.
module conv_line_buffer #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 6
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Shift one pixel per accepted beat; the tail is the same column one row earlier.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end else begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= r_mem[i];
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution with internal line buffers and loadable signed taps.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int K      = 3,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic                                    in_valid,
  input  logic                                    in_sof,
  input  logic [DATA_W-1:0]                       in_pixel,
  input  logic                                    w_we,
  input  logic [clog2(K*K)-1:0]                   w_addr,
  input  logic [COEF_W-1:0]                       w_data,
  output logic                                    out_valid,
  output logic                                    out_last,
  output logic signed [out_w(DATA_W,COEF_W,K)-1:0] out_data
);

  localparam int OUT_W  = out_w(DATA_W, COEF_W, K);
  localparam int TAPS   = K * K;
  localparam int AW     = clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ROW_W  = clog2(IMG_H);
  localparam int COL_W  = clog2(IMG_W);

  logic [ROW_W-1:0]         r_row;
  logic [COL_W-1:0]         r_col;
  logic [DATA_W-1:0]        r_win [TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic                     r_we_d;
  logic [AW-1:0]            r_addr_d;
  logic [COEF_W-1:0]        r_data_d;
  logic                     r_v0, r_last0, r_v1, r_last1;
  logic signed [PROD_W-1:0] r_prod [TAPS];

  logic [DATA_W-1:0]        w_lb_in  [K-1];
  logic [DATA_W-1:0]        w_lb_out [K-1];
  logic [DATA_W-1:0]        w_col_new [K];
  logic [ROW_W-1:0]         w_pos_row;
  logic [COL_W-1:0]         w_pos_col;
  logic                     w_win_ok, w_is_last;
  logic signed [PROD_W-1:0] w_prod [TAPS];
  logic signed [OUT_W-1:0]  w_sum, w_res;

  for (genvar j = 0; j < K-1; j++) begin : g_lb
    if (j == 0) begin : g_first
      assign w_lb_in[j] = in_pixel;
    end else begin : g_next
      assign w_lb_in[j] = w_lb_out[j-1];
    end
    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
      .CLK(CLK), .reset(reset), .i_en(in_valid), .i_data(w_lb_in[j]), .o_data(w_lb_out[j])
    );
    // Window row K-2-j sees the pixel j+1 rows above the incoming one.
    assign w_col_new[K-2-j] = w_lb_out[j];
  end
  assign w_col_new[K-1] = in_pixel;

  assign w_pos_row = in_sof ? '0 : r_row;
  assign w_pos_col = in_sof ? '0 : r_col;
  assign w_win_ok  = (w_pos_row >= ROW_W'(K-1)) && (w_pos_col >= COL_W'(K-1));
  assign w_is_last = (w_pos_row == ROW_W'(IMG_H-1)) && (w_pos_col == COL_W'(IMG_W-1));

  // Raster position of the next pixel; in_sof re-anchors the accepted pixel at (0,0).
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (in_valid) begin
      if (w_pos_col == COL_W'(IMG_W-1)) begin
        r_col <= '0;
        r_row <= (w_pos_row == ROW_W'(IMG_H-1)) ? '0 : w_pos_row + ROW_W'(1);
      end else begin
        r_col <= w_pos_col + COL_W'(1);
        r_row <= w_pos_row;
      end
    end else begin
      r_row <= r_row;
      r_col <= r_col;
    end
  end

  // Window slides left one column per accepted pixel; tag marks a complete window.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
      r_v0    <= 1'b0;
      r_last0 <= 1'b0;
    end else begin
      r_v0    <= in_valid && w_win_ok;
      r_last0 <= in_valid && w_win_ok && w_is_last;
      if (in_valid) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) r_win[tap_idx(r, c, K)] <= r_win[tap_idx(r, c+1, K)];
          r_win[tap_idx(r, K-1, K)] <= w_col_new[r];
        end
      end else begin
        for (int i = 0; i < TAPS; i++) r_win[i] <= r_win[i];
      end
    end
  end

  // Writes land in the bank one edge late so a window taken on the write edge multiplies old taps.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_we_d   <= 1'b0;
      r_addr_d <= '0;
      r_data_d <= '0;
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else begin
      r_we_d   <= w_we;
      r_addr_d <= w_addr;
      r_data_d <= w_data;
      if (r_we_d && (r_addr_d < AW'(TAPS))) begin
        r_coef[r_addr_d] <= $signed(r_data_d);
      end else begin
        r_coef[r_addr_d] <= r_coef[r_addr_d];
      end
    end
  end

  // Pixels are zero-extended so they stay non-negative in the signed multiply.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      w_prod[i] = $signed(PROD_W'(r_win[i])) * PROD_W'(r_coef[i]);
    end
  end

  // Stage 1: register all products.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_prod[i] <= '0;
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) r_prod[i] <= w_prod[i];
      r_v1    <= r_v0;
      r_last1 <= r_last0;
    end
  end

  // Adder tree at full width, then optional ReLU clamp.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < TAPS; i++) w_sum = w_sum + OUT_W'(r_prod[i]);
`ifdef CONV_RELU_EN
    if (w_sum[OUT_W-1]) begin
      w_res = '0;
    end else begin
      w_res = w_sum;
    end
`else
    w_res = w_sum;
`endif
  end

  // Stage 2: registered result; data holds between results.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= r_v1;
      out_last  <= r_v1 && r_last1;
      if (r_v1) begin
        out_data <= w_res;
      end else begin
        out_data <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream: table of kernels plus a frame-level reference model.
module tb_conv2d_stream;

  localparam int K = 3;
  localparam int W = 6;
  localparam int H = 6;

  logic              CLK;
  logic              reset;
  logic              in_valid;
  logic              in_sof;
  logic [3:0]        in_pixel;
  logic              w_we;
  logic [3:0]        w_addr;
  logic [3:0]        w_data;
  logic              out_valid;
  logic              out_last;
  logic signed [11:0] out_data;

  conv2d_stream dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int val;
    bit last;
    int due;
  } exp_t;

  typedef struct {
    int kind;        // 0 identity, 1 all-ones, 2 all-minus-one
    int exp_first;
    int exp_second;
    int exp_count;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   t      = 0;
  exp_t q[$];
  int   cap_data[$];
  bit   cap_last[$];
  int   ones_seq[$];
  int   img [H][W];
  int   mcoef [K*K];
  int   mrow = 0;
  int   mcol = 0;
  int   last_data = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (step %0d)", name, act, exp, t);
    end
  endtask

  // Called once per cycle at the falling edge: check outputs, then model the coming rising edge.
  task automatic sb_step();
    int   pr, pc, s;
    bit   ev;
    exp_t e;
    t++;
    if (!reset) begin
      q.delete();
      mrow = 0;
      mcol = 0;
      foreach (mcoef[i]) mcoef[i] = 0;
      last_data = 0;
      check("rst_valid", int'(out_valid), 0);
      check("rst_last", int'(out_last), 0);
      check("rst_data", int'(out_data), 0);
    end else begin
      ev = (q.size() > 0) && (q[0].due == t);
      check("out_valid", int'(out_valid), int'(ev));
      if (ev) begin
        e = q.pop_front();
        check("out_data", int'(out_data), e.val);
        check("out_last", int'(out_last), int'(e.last));
        last_data = e.val;
      end else begin
        check("hold_data", int'(out_data), last_data);
        check("idle_last", int'(out_last), 0);
      end
      if (out_valid === 1'b1) begin
        cap_data.push_back(int'(out_data));
        cap_last.push_back(out_last);
      end
      if (in_valid) begin
        pr = in_sof ? 0 : mrow;
        pc = in_sof ? 0 : mcol;
        img[pr][pc] = int'(in_pixel);
        if (pr >= K-1 && pc >= K-1) begin
          s = 0;
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              s += img[pr-K+1+r][pc-K+1+c] * mcoef[r*K+c];
`ifdef CONV_RELU_EN
          if (s < 0) s = 0;
`endif
          e.val  = s;
          e.last = (pr == H-1) && (pc == W-1);
          e.due  = t + 3;
          q.push_back(e);
        end
        pc = pc + 1;
        if (pc == W) begin
          pc = 0;
          pr = (pr + 1) % H;
        end
        mrow = pr;
        mcol = pc;
      end
      if (w_we && int'(w_addr) < K*K) mcoef[w_addr] = int'($signed(w_data));
    end
  endtask

  task automatic drive(input bit rst, input bit v, input bit sof, input int pix,
                       input bit we, input int addr, input int data);
    @(posedge CLK);
    #2;
    reset    = rst;
    in_valid = v;
    in_sof   = sof;
    in_pixel = 4'(pix);
    w_we     = we;
    w_addr   = 4'(addr);
    w_data   = 4'(data);
    @(negedge CLK);
    sb_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  function automatic int coef_of(input int kind, input int tap);
    case (kind)
      0:       return (tap == 4) ? 1 : 0;
      1:       return 1;
      2:       return -1;
      default: return 0;
    endcase
  endfunction

  task automatic load_kernel(input int kind);
    for (int i = 0; i < K*K; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b1, i, coef_of(kind, i));
    idle(1);
  endtask

  // Sends npix pixels of the test image; optional gaps and a tap-4 := 2 write on pixel wr_at.
  task automatic send_frame(input int npix, input bit gaps, input int wr_at);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      drive(1'b1, 1'b1, i == 0, (i + 1) % 16, i == wr_at, 4, 2);
    end
    idle(5);
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_last.delete();
  endtask

  vec_t tbl[3];
  int   bad_last;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0;

`ifdef CONV_RELU_EN
    tbl[2] = '{kind: 2, exp_first: 0, exp_second: 0, exp_count: 16};
`else
    tbl[2] = '{kind: 2, exp_first: -72, exp_second: -65, exp_count: 16};
`endif
    tbl[0] = '{kind: 0, exp_first: 8, exp_second: 9, exp_count: 16};
    tbl[1] = '{kind: 1, exp_first: 72, exp_second: 65, exp_count: 16};

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    idle(2);

    // Kernel table with continuous input.
    for (int v = 0; v < 3; v++) begin
      load_kernel(tbl[v].kind);
      clear_caps();
      send_frame(W*H, 1'b0, -1);
      check("tbl_count", cap_data.size(), tbl[v].exp_count);
      if (cap_data.size() >= 2) begin
        check("tbl_first", cap_data[0], tbl[v].exp_first);
        check("tbl_second", cap_data[1], tbl[v].exp_second);
      end
      bad_last = 0;
      foreach (cap_last[i]) if (cap_last[i] != (i == 15)) bad_last++;
      check("tbl_last_flags", bad_last, 0);
      if (tbl[v].kind == 1) ones_seq = cap_data;
    end

    // Random input gaps with the all-ones kernel must reproduce the continuous sequence.
    load_kernel(1);
    clear_caps();
    send_frame(W*H, 1'b1, -1);
    check("gap_count", cap_data.size(), ones_seq.size());
    for (int i = 0; i < 16; i++)
      if (i < cap_data.size() && i < ones_seq.size()) check("gap_seq", cap_data[i], ones_seq[i]);

    // Reset mid-frame, then a fresh frame.
    send_frame(20, 1'b0, -1);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    idle(1);
    clear_caps();
    load_kernel(1);
    send_frame(W*H, 1'b0, -1);
    check("rst_frame_count", cap_data.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < cap_data.size() && i < ones_seq.size()) check("rst_frame_seq", cap_data[i], ones_seq[i]);

    // Centre tap rewritten on the edge that accepts pixel (3,3).
    load_kernel(0);
    clear_caps();
    send_frame(W*H, 1'b0, 21);
    check("wr_count", cap_data.size(), 16);
    if (cap_data.size() == 16) begin
      check("wr_before0", cap_data[0], 8);
      check("wr_before4", cap_data[4], 14);
      check("wr_same_edge", cap_data[5], 15);
      check("wr_after7", cap_data[7], 2);
      check("wr_after15", cap_data[15], 26);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
